// File: rtl/divu_pkg.sv
// Shared types and constants for the sequential unsigned divider.
package divu_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam int DIVU_WIDTH_DEFAULT = 8;

   // Step counter width, sized to hold 0..WIDTH.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction
endpackage

// File: rtl/divu_step.sv
// One combinational restoring-division step: shift {R,Q} left, then subtract divisor when it fits.
module divu_step
   import divu_pkg::*;
#(
   parameter int WIDTH = DIVU_WIDTH_DEFAULT
) (
   input  logic [WIDTH:0]   r,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   r_next,
   output logic [WIDTH-1:0] q_next
);
   // One extra bit keeps the shifted value exact even if R ever reaches 2^WIDTH.
   logic [WIDTH+1:0] sh;
   logic             ge;

   assign sh = {r, q[WIDTH-1]};
   assign ge = (sh >= {2'b00, divisor});

   always_comb begin
      r_next = (WIDTH+1)'(sh);
      q_next = {q[WIDTH-2:0], 1'b0};
      if (ge) begin
         r_next    = (WIDTH+1)'(sh - {2'b00, divisor});
         q_next[0] = 1'b1;
      end
   end
endmodule

// File: rtl/divu_seq.sv
// Sequential unsigned restoring divider, 2*WIDTH / WIDTH, one quotient bit per cycle.
// DIVU_SEQ_EARLY_EXC_EN: divide-by-zero/overflow skip CALC and finish one cycle after accept.
module divu_seq
   import divu_pkg::*;
#(
   parameter int WIDTH = DIVU_WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               div_by_zero,
   output logic               overflow
);
   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH:0]   r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] dvsr;
   logic [WIDTH-1:0] exc_rem;
   logic [CW-1:0]    cnt;
   logic             dz_q;
   logic             ov_q;

   logic [WIDTH:0]   r_nx;
   logic [WIDTH-1:0] q_nx;
   logic             dz_in;
   logic             ov_in;

   assign in_ready = (state == IDLE);

   // Exceptions are decided from the raw operands at capture time.
   assign dz_in = (divisor == '0);
   assign ov_in = !dz_in && (dividend[2*WIDTH-1:WIDTH] >= divisor);

   divu_step #(.WIDTH(WIDTH)) u_step (
      .r       (r),
      .q       (q),
      .divisor (dvsr),
      .r_next  (r_nx),
      .q_next  (q_nx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         r           <= '0;
         q           <= '0;
         dvsr        <= '0;
         exc_rem     <= '0;
         cnt         <= '0;
         dz_q        <= 1'b0;
         ov_q        <= 1'b0;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  r       <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
                  q       <= dividend[WIDTH-1:0];
                  dvsr    <= divisor;
                  cnt     <= '0;
                  dz_q    <= dz_in;
                  ov_q    <= ov_in;
                  exc_rem <= dz_in ? dividend[WIDTH-1:0] : '0;
`ifdef DIVU_SEQ_EARLY_EXC_EN
                  if (dz_in || ov_in) begin
                     state       <= DONE;
                     out_valid   <= 1'b1;
                     quotient    <= '1;
                     remainder   <= dz_in ? dividend[WIDTH-1:0] : '0;
                     div_by_zero <= dz_in;
                     overflow    <= ov_in;
                  end else begin
                     state <= CALC;
                  end
`else
                  state <= CALC;
`endif
               end
            end
            CALC: begin
               // Exception operations still iterate here; their datapath result is discarded.
               r   <= r_nx;
               q   <= q_nx;
               cnt <= cnt + 1'b1;
               if (cnt == LAST_STEP) begin
                  state       <= DONE;
                  out_valid   <= 1'b1;
                  div_by_zero <= dz_q;
                  overflow    <= ov_q;
                  if (dz_q || ov_q) begin
                     quotient  <= '1;
                     remainder <= exc_rem;
                  end else begin
                     quotient  <= q_nx;
                     remainder <= r_nx[WIDTH-1:0];
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
